pc_seq_ctrl: RTL
================

Name: pc_seq_ctrl

Overview:
- Program-counter sequencer for the core's fetch stage.
- Owns the PC register and advances it by one each cycle.
- On a taken branch, loads an absolute target from an internal branch-target lookup indexed by the instruction's target field, then inserts a one-cycle fetch bubble.
- Provides start/done handshake with the testbench/top level and honours stalls from downstream.

Parameters:
- D, 12, PC width in bits.
- LUT_AW, 5, branch-target index width (32 slots; 17 mapped).
- START_ADDR, 0, PC value loaded on reset and on start.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse; begins or restarts program execution.
- stall  input  1  hold PC this cycle (RUN only).
- halt  input  1  decoded halt instruction at current PC.
- branch_en  input  1  decoded branch instruction at current PC.
- branch_cond  input  1  ALU condition flag; taken when branch_en && branch_cond.
- lut_idx  input  LUT_AW  branch-target index from instruction.
- prog_ctr  output  D  current PC to instruction ROM.
- fetch_valid  output  1  instruction at prog_ctr is to be executed this cycle.
- flush  output  1  high during branch bubble; downstream discards its fetch.
- busy  output  1  high in RUN or BRANCH.
- done  output  1  high in DONE; held until next start.

Behaviour:
- Reset (Reset_n low, async): state=IDLE, prog_ctr=START_ADDR, fetch_valid=0, flush=0, busy=0, done=0. All outputs are registered.
- IDLE:
  - start -> RUN, prog_ctr=START_ADDR.
  - All other inputs ignored.
- RUN (fetch_valid=1, busy=1). Priority order each cycle:
  - stall: hold prog_ctr and state. Halt and branch are re-evaluated next cycle.
  - halt: -> DONE, prog_ctr held.
  - Taken branch: prog_ctr <= target(lut_idx), -> BRANCH.
  - Else, prog_ctr <= prog_ctr+1.
  - At prog_ctr = 2^D-1 with no branch/halt: -> DONE. No wrap to 0.
  - Not-taken branch (branch_en=1, branch_cond=0) is treated as an ordinary increment.
- BRANCH (fetch_valid=0, flush=1, busy=1):
  - Exactly one cycle; prog_ctr holds the new target.
  - stall, halt, branch and start are ignored.
  - -> RUN next cycle.
- DONE (done=1, fetch_valid=0, busy=0):
  - start -> RUN, prog_ctr=START_ADDR, done cleared the same edge.
- start is ignored in RUN and BRANCH.
- Target lookup is combinational within the sub-module; the branch-to-new-PC latency is 1 clock.
- Mapped targets (idx:target):
  - 0:10, 1:30, 2:39, 3:48, 4:56, 5:61, 6:64, 7:71, 8:78
  - 9:85, 10:91, 11:108, 12:116, 13:125, 14:133, 15:138, 16:141
  - Unmapped indices (17-31) return 0.
- Reset asserted mid-RUN or mid-BRANCH returns to IDLE immediately. No flush pulse is emitted.

Optional Feature:
- Macro: PC_SEQ_BAD_TARGET_TRAP_EN.
- Defined:
  - Adds output bad_target (1 bit, reset 0).
  - A taken branch with unmapped lut_idx goes -> DONE instead of BRANCH; prog_ctr is held.
  - bad_target is set and stays sticky until the next start.
- Undefined:
  - No extra port.
  - Unmapped index branches to PC 0 through BRANCH as normal.

Decomposition:
- Package pc_seq_pkg:
  - State enum {IDLE, RUN, BRANCH, DONE} as typedef pc_state_t.
  - Constant N_TARGETS=17.
  - Constant target table array.
- One sub-module, pc_target_lut: combinational lut_idx -> D-bit target, reading the package table; default 0.
- The FSM and PC register live in pc_seq_ctrl.

Test Plan:
- Reset, then start; no branch/halt for 5 cycles -> prog_ctr 0,1,2,3,4,5; fetch_valid=1; busy=1.
- At PC=4: branch_en=1, branch_cond=1, lut_idx=2 -> next cycle prog_ctr=39, flush=1, fetch_valid=0; following cycle prog_ctr=39, fetch_valid=1, then 40.
- At PC=7: stall=1 for 3 cycles with branch_en=1, branch_cond=1, lut_idx=16 -> PC held at 7 during stall; branch to 141 only after stall drops.
- At PC=9: halt=1 and taken branch together -> DONE, done=1, prog_ctr=9; start pulse -> prog_ctr=0, RUN.
- Taken branch with lut_idx=20:
  - Trap undefined: prog_ctr=0 after the bubble.
  - Trap defined: DONE, bad_target=1, prog_ctr held.
- Reset_n pulled low mid-BRANCH (async, between edges) -> outputs reset immediately; state IDLE; start required to resume.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// ============================================================================
// Module      : pc_seq_pkg
// Description : Shared types and branch-target table for the PC sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        BRANCH = 2'd2,
        DONE   = 2'd3
    } pc_state_t;

    localparam int N_TARGETS = 17;

    localparam int TARGET_TABLE [N_TARGETS] = '{
        10, 30, 39, 48, 56, 61, 64, 71, 78,
        85, 91, 108, 116, 125, 133, 138, 141
    };

    function automatic logic is_mapped(input int unsigned idx);
        return (idx < N_TARGETS);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_seq_ctrl_if.sv
// ============================================================================
// Module      : pc_seq_ctrl_if
// Description : Control/fetch bundle of the PC sequencer. bad_target exists
//               only when PC_SEQ_BAD_TARGET_TRAP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_seq_ctrl_if #(
    parameter int D      = 12,
    parameter int LUT_AW = 5
);
    logic              start;
    logic              stall;
    logic              halt;
    logic              branch_en;
    logic              branch_cond;
    logic [LUT_AW-1:0] lut_idx;
    logic [D-1:0]      prog_ctr;
    logic              fetch_valid;
    logic              flush;
    logic              busy;
    logic              done;
`ifdef PC_SEQ_BAD_TARGET_TRAP_EN
    logic              bad_target;

    modport master (
        output start, stall, halt, branch_en, branch_cond, lut_idx,
        input  prog_ctr, fetch_valid, flush, busy, done, bad_target
    );

    modport slave (
        input  start, stall, halt, branch_en, branch_cond, lut_idx,
        output prog_ctr, fetch_valid, flush, busy, done, bad_target
    );
`else
    modport master (
        output start, stall, halt, branch_en, branch_cond, lut_idx,
        input  prog_ctr, fetch_valid, flush, busy, done
    );

    modport slave (
        input  start, stall, halt, branch_en, branch_cond, lut_idx,
        output prog_ctr, fetch_valid, flush, busy, done
    );
`endif
endinterface

`default_nettype wire

// File: rtl/pc_target_lut.sv
// ============================================================================
// Module      : pc_target_lut
// Description : Combinational branch-target lookup; unmapped indices give 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_target_lut
    import pc_seq_pkg::*;
#(
    parameter int D      = 12,
    parameter int LUT_AW = 5
) (
    input  wire logic [LUT_AW-1:0] lut_idx_i,
    output logic      [D-1:0]      target_o
);

    always_comb begin
        target_o = '0;
        for (int i = 0; i < N_TARGETS; i++) begin
            if (32'(lut_idx_i) == i) begin
                target_o = D'(TARGET_TABLE[i]);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_seq_ctrl.sv
// ============================================================================
// Module      : pc_seq_ctrl
// Description : Fetch-stage PC sequencer with one-cycle branch bubble.
//               Optional macro PC_SEQ_BAD_TARGET_TRAP_EN traps unmapped targets.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_seq_ctrl
    import pc_seq_pkg::*;
#(
    parameter int D          = 12,
    parameter int LUT_AW     = 5,
    parameter int START_ADDR = 0
) (
    input wire logic     Clk,
    input wire logic     Reset_n,
    pc_seq_ctrl_if.slave bus
);

    localparam logic [D-1:0] C_START  = D'(START_ADDR);
    localparam logic [D-1:0] C_PC_MAX = {D{1'b1}};

    pc_state_t      state_q, state_d;
    logic [D-1:0]   pc_q, pc_d;
    logic           fetch_valid_q, fetch_valid_d;
    logic           flush_q, flush_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [D-1:0]   w_target;
    logic           w_taken;
    logic           w_trap;

    pc_target_lut #(
        .D      (D),
        .LUT_AW (LUT_AW)
    ) u_target_lut (
        .lut_idx_i (bus.lut_idx),
        .target_o  (w_target)
    );

    assign w_taken = bus.branch_en & bus.branch_cond;

`ifdef PC_SEQ_BAD_TARGET_TRAP_EN
    logic bad_target_q, bad_target_d;
    assign w_trap         = ~is_mapped(32'(bus.lut_idx));
    assign bus.bad_target = bad_target_q;
`else
    assign w_trap = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
`ifdef PC_SEQ_BAD_TARGET_TRAP_EN
        bad_target_d = bad_target_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    pc_d    = C_START;
`ifdef PC_SEQ_BAD_TARGET_TRAP_EN
                    bad_target_d = 1'b0;
`endif
                end
            end
            RUN: begin
                // A stalled cycle defers halt/branch decisions to the next cycle.
                if (!bus.stall) begin
                    if (bus.halt) begin
                        state_d = DONE;
                    end else if (w_taken) begin
                        if (w_trap) begin
                            state_d = DONE;
`ifdef PC_SEQ_BAD_TARGET_TRAP_EN
                            bad_target_d = 1'b1;
`endif
                        end else begin
                            state_d = BRANCH;
                            pc_d    = w_target;
                        end
                    end else if (pc_q == C_PC_MAX) begin
                        state_d = DONE;
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
            end
            BRANCH: begin
                state_d = RUN;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        fetch_valid_d = (state_d == RUN);
        flush_d       = (state_d == BRANCH);
        busy_d        = (state_d == RUN) || (state_d == BRANCH);
        done_d        = (state_d == DONE);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= IDLE;
            pc_q          <= C_START;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
`ifdef PC_SEQ_BAD_TARGET_TRAP_EN
            bad_target_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            flush_q       <= flush_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
`ifdef PC_SEQ_BAD_TARGET_TRAP_EN
            bad_target_q  <= bad_target_d;
`endif
        end
    end

    assign bus.prog_ctr    = pc_q;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.flush       = flush_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

`default_nettype wire
